// File: rtl/piezo_song_player.sv
// Piezo melody engine: walks ROM note words {END, DUR, HP} for the selected song and
// drives a square wave with a fixed silent gap at the end of every note.
module piezo_song_player #(
  parameter int unsigned NUM_SONGS   = 2,
  parameter int unsigned IDX_W       = 8,
  parameter int unsigned DIV_W       = 11,
  parameter int unsigned DUR_W       = 4,
  parameter int unsigned UNIT_CYCLES = 250000,
  parameter int unsigned GAP_CYCLES  = 20000,
  parameter int unsigned SEL_W       = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
  input  logic                     CLK_1MHZ,
  input  logic                     RESETN,
  input  logic                     PLAY,
  input  logic [SEL_W-1:0]         SEL,
  input  logic                     LOOP,
  input  logic [1:0]               TEMPO,
  output logic [SEL_W+IDX_W-1:0]   ROM_ADDR,
  input  logic [DUR_W+DIV_W:0]     ROM_DATA,
  output logic                     SONG,
  output logic                     BUSY,
  output logic [IDX_W-1:0]         NOTE_IDX,
  output logic                     DONE
);

  // Sized so the longest note (max DUR at TEMPO=0) cannot overflow.
  localparam int unsigned CNT_W = $clog2(((2 ** DUR_W) - 1) * UNIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] UNIT = CNT_W'(UNIT_CYCLES);
  localparam logic [CNT_W-1:0] GAP  = CNT_W'(GAP_CYCLES);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_TONE  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             play_q, play_d;
  logic             armed_q, armed_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0] hp_q, hp_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tone_len_q, tone_len_d;
  logic             song_q, song_d;
  logic             done_q, done_d;

  logic             rom_end;
  logic [DUR_W-1:0] rom_dur;
  logic [DIV_W-1:0] rom_hp;
  logic [DUR_W-1:0] dur_eff;
  logic [CNT_W-1:0] unit_len;
  logic [CNT_W-1:0] note_len;

  assign rom_end  = ROM_DATA[DUR_W+DIV_W];
  assign rom_dur  = ROM_DATA[DIV_W +: DUR_W];
  assign rom_hp   = ROM_DATA[DIV_W-1:0];
  assign dur_eff  = (rom_dur == '0) ? DUR_W'(1) : rom_dur;
  assign unit_len = UNIT >> TEMPO;
  assign note_len = CNT_W'(dur_eff) * unit_len;

  always_comb begin
    state_d    = state_q;
    play_d     = PLAY;
    armed_d    = armed_q | ~PLAY;
    sel_d      = sel_q;
    idx_d      = idx_q;
    hp_d       = hp_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    tone_len_d = tone_len_q;
    song_d     = song_q;
    done_d     = 1'b0;
    if (!PLAY) begin
      state_d = ST_IDLE;
      song_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // armed_q blocks a start from PLAY already high when reset is released.
          if (!play_q && armed_q && !done_q) begin
            sel_d   = (32'(SEL) < NUM_SONGS) ? SEL : '0;
            idx_d   = '0;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          if (rom_end || idx_q == '1) begin
            if (LOOP) begin
              idx_d   = '0;
              state_d = ST_FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            hp_d   = rom_hp;
            div_d  = '0;
            cnt_d  = '0;
            song_d = 1'b0;
            if (note_len > GAP) begin
              tone_len_d = note_len - GAP;
              state_d    = ST_TONE;
            end else begin
              state_d = ST_GAP;
            end
          end
        end
        ST_TONE: begin
          if (hp_q != '0) begin
            if (div_q == hp_q) begin
              div_d  = '0;
              song_d = ~song_q;
            end else begin
              div_d = div_q + 1'b1;
            end
          end
          if (cnt_q == tone_len_q - 1'b1) begin
            cnt_d   = '0;
            song_d  = 1'b0;
            state_d = ST_GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          song_d = 1'b0;
          if (cnt_q == GAP - 1'b1) begin
            cnt_d   = '0;
            idx_d   = idx_q + 1'b1;
            state_d = ST_FETCH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          song_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_1MHZ or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= ST_IDLE;
      play_q     <= 1'b0;
      armed_q    <= 1'b0;
      sel_q      <= '0;
      idx_q      <= '0;
      hp_q       <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      tone_len_q <= '0;
      song_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      play_q     <= play_d;
      armed_q    <= armed_d;
      sel_q      <= sel_d;
      idx_q      <= idx_d;
      hp_q       <= hp_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      tone_len_q <= tone_len_d;
      song_q     <= song_d;
      done_q     <= done_d;
    end
  end

  assign ROM_ADDR = {sel_q, idx_q};
  assign SONG     = song_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign NOTE_IDX = idx_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_piezo_song_player.sv
// Directed bench for piezo_song_player with a small behavioural synchronous ROM.
module tb_piezo_song_player;

  logic        clk = 1'b0;
  logic        rstn;
  logic        play;
  logic [0:0]  sel;
  logic        loop_en;
  logic [1:0]  tempo;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic        song;
  logic        busy;
  logic [2:0]  note_idx;
  logic        done;

  logic [15:0] rom [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  piezo_song_player #(
    .NUM_SONGS(2), .IDX_W(3), .DIV_W(11), .DUR_W(4), .UNIT_CYCLES(20), .GAP_CYCLES(4)
  ) dut (
    .CLK_1MHZ(clk), .RESETN(rstn), .PLAY(play), .SEL(sel), .LOOP(loop_en), .TEMPO(tempo),
    .ROM_ADDR(rom_addr), .ROM_DATA(rom_data), .SONG(song), .BUSY(busy),
    .NOTE_IDX(note_idx), .DONE(done)
  );

  function automatic logic [15:0] mk(input logic e, input logic [3:0] d, input logic [10:0] h);
    return {e, d, h};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns one cycle after the start edge (state FETCH).
  task automatic start();
    play = 1'b0;
    tick();
    tick();
    play = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    chk("reset_song", {7'd0, song}, 8'd0);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_done", {7'd0, done}, 8'd0);
    chk("reset_idx", {5'd0, note_idx}, 8'd0);
    chk("reset_addr", {4'd0, rom_addr}, 8'd0);
  endtask

  task automatic test_basic_note();
    rom[0] = mk(1'b0, 4'd2, 11'd2);
    rom[1] = mk(1'b1, 4'd0, 11'd0);
    loop_en = 1'b0;
    start();
    chk("basic_busy_fetch", {7'd0, busy}, 8'd1);
    chk("basic_addr_fetch", {4'd0, rom_addr}, 8'd0);
    tick();
    tick();
    for (int k = 0; k < 36; k++) begin
      chk("basic_tone", {7'd0, song}, {7'd0, 1'((k / 3) % 2)});
      tick();
    end
    for (int g = 0; g < 4; g++) begin
      chk("basic_gap_song", {7'd0, song}, 8'd0);
      chk("basic_gap_busy", {7'd0, busy}, 8'd1);
      tick();
    end
    chk("basic_fetch2_addr", {4'd0, rom_addr}, 8'd1);
    chk("basic_fetch2_done", {7'd0, done}, 8'd0);
    tick();
    tick();
    chk("basic_done", {7'd0, done}, 8'd1);
    chk("basic_done_busy", {7'd0, busy}, 8'd0);
    chk("basic_note_idx", {5'd0, note_idx}, 8'd1);
    tick();
    chk("basic_done_single", {7'd0, done}, 8'd0);
    tick();
    tick();
    chk("basic_no_restart", {7'd0, busy}, 8'd0);
    play = 1'b0;
  endtask

  task automatic test_rest();
    rom[0] = mk(1'b0, 4'd1, 11'd0);
    rom[1] = mk(1'b1, 4'd0, 11'd0);
    start();
    tick();
    tick();
    for (int k = 0; k < 20; k++) begin
      chk("rest_song", {7'd0, song}, 8'd0);
      chk("rest_busy", {7'd0, busy}, 8'd1);
      tick();
    end
    chk("rest_fetch_addr", {4'd0, rom_addr}, 8'd1);
    tick();
    tick();
    chk("rest_done", {7'd0, done}, 8'd1);
    play = 1'b0;
  endtask

  task automatic test_loop();
    logic [3:0] prev;
    int wraps = 0;
    int dones = 0;
    rom[0] = mk(1'b0, 4'd2, 11'd2);
    rom[1] = mk(1'b1, 4'd0, 11'd0);
    loop_en = 1'b1;
    start();
    prev = rom_addr;
    for (int c = 2; c <= 134; c++) begin
      tick();
      if (prev == 4'd1 && rom_addr == 4'd0) wraps++;
      if (done) dones++;
      if (c == 45) chk("loop_addr_back", {4'd0, rom_addr}, 8'd0);
      if (c == 50) chk("loop_replay_song", {7'd0, song}, 8'd1);
      prev = rom_addr;
    end
    chk("loop_wraps", 8'(wraps), 8'd3);
    chk("loop_no_done", 8'(dones), 8'd0);
    chk("loop_busy", {7'd0, busy}, 8'd1);
    play = 1'b0;
    tick();
    chk("loop_stop_busy", {7'd0, busy}, 8'd0);
    chk("loop_stop_done", {7'd0, done}, 8'd0);
    loop_en = 1'b0;
  endtask

  task automatic test_stop();
    int dones = 0;
    start();
    for (int c = 2; c <= 12; c++) tick();
    chk("stop_song_before", {7'd0, song}, 8'd1);
    play = 1'b0;
    tick();
    chk("stop_song", {7'd0, song}, 8'd0);
    chk("stop_busy", {7'd0, busy}, 8'd0);
    for (int c = 0; c < 5; c++) begin
      if (done) dones++;
      tick();
    end
    chk("stop_no_done", 8'(dones), 8'd0);
    play = 1'b1;
    tick();
    chk("stop_restart_busy", {7'd0, busy}, 8'd1);
    chk("stop_restart_addr", {4'd0, rom_addr}, 8'd0);
    chk("stop_restart_idx", {5'd0, note_idx}, 8'd0);
    play = 1'b0;
    tick();
  endtask

  task automatic test_sel_tempo();
    rom[8] = mk(1'b0, 4'd2, 11'd5);
    rom[9] = mk(1'b1, 4'd0, 11'd0);
    sel = 1'b1;
    tempo = 2'd1;
    start();
    chk("sel_addr", {4'd0, rom_addr}, 8'd8);
    sel = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 16; k++) begin
      chk("sel_tone", {7'd0, song}, {7'd0, 1'((k / 6) % 2)});
      tick();
    end
    for (int g = 0; g < 4; g++) begin
      chk("sel_gap", {7'd0, song}, 8'd0);
      tick();
    end
    chk("sel_fetch2_addr", {4'd0, rom_addr}, 8'd9);
    tick();
    tick();
    chk("sel_done", {7'd0, done}, 8'd1);
    play = 1'b0;
  endtask

  task automatic test_reset_mid_gap();
    sel = 1'b1;
    tempo = 2'd1;
    start();
    for (int c = 2; c <= 20; c++) tick();
    chk("rst_pre_busy", {7'd0, busy}, 8'd1);
    rstn = 1'b0;
    #1;
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_addr", {4'd0, rom_addr}, 8'd0);
    chk("rst_song", {7'd0, song}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    #3;
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rst_held_play", {7'd0, busy}, 8'd0);
    end
    sel = 1'b0;
    play = 1'b0;
    tick();
    play = 1'b1;
    tick();
    chk("rst_new_edge_busy", {7'd0, busy}, 8'd1);
    chk("rst_new_edge_addr", {4'd0, rom_addr}, 8'd0);
    play = 1'b0;
    tick();
    tempo = 2'd0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = mk(1'b1, 4'd0, 11'd0);
    rstn = 1'b0;
    play = 1'b0;
    sel = 1'b0;
    loop_en = 1'b0;
    tempo = 2'd0;
    #12;
    test_reset();
    #5;
    rstn = 1'b1;
    tick();
    test_basic_note();
    test_rest();
    test_loop();
    test_stop();
    test_sel_tempo();
    test_reset_mid_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piezo_song_player.md
Name: piezo_song_player

Overview:
- Generalised piezo melody engine: plays one of NUM_SONGS note sequences stored in an external synchronous ROM and drives a single piezo output with a square wave.
- Note pitch, duration and end-of-song come from ROM words, so songs change without RTL edits.
- Adds start-on-edge, per-note articulation gap, loop mode, tempo scaling and status outputs.
- Sits between board switches/keys and the piezo pin.

Parameters:
- NUM_SONGS, 2, number of selectable songs; SEL_W = max(1, clog2(NUM_SONGS)).
- IDX_W, 8, note-index width; each song occupies 2^IDX_W consecutive ROM words starting at SEL*2^IDX_W.
- DIV_W, 11, half-period field width, in CLK_1MHZ cycles.
- DUR_W, 4, duration field width, in time units.
- UNIT_CYCLES, 250000, CLK_1MHZ cycles per time unit at TEMPO=0.
- GAP_CYCLES, 20000, silent cycles at the end of every note; must be < UNIT_CYCLES.

Ports:
- CLK_1MHZ  in  1  system clock.
- RESETN  in  1  asynchronous, active-low reset.
- PLAY  in  1  level; rising edge starts, low stops.
- SEL  in  SEL_W  song select, sampled at start.
- LOOP  in  1  restart at end-of-song instead of finishing.
- TEMPO  in  2  unit length = UNIT_CYCLES >> TEMPO, sampled at each note load.
- ROM_ADDR  out  SEL_W+IDX_W  ROM read address.
- ROM_DATA  in  1+DUR_W+DIV_W  word {END, DUR, HP}, valid 1 cycle after ROM_ADDR.
- SONG  out  1  piezo drive.
- BUSY  out  1  high in any state except IDLE.
- NOTE_IDX  out  IDX_W  index of the current note.
- DONE  out  1  one-cycle pulse on normal (non-loop) completion.

Behaviour:
- Reset (async): state IDLE; SONG=0, BUSY=0, DONE=0, NOTE_IDX=0, ROM_ADDR=0; all counters 0; PLAY edge register 0.
- All state is registered; outputs change only on posedge CLK_1MHZ.
- States: IDLE, FETCH, LOAD, TONE, GAP.
- IDLE:
  - PLAY registered 0->1: latch SEL into sel_q (SEL values >= NUM_SONGS map to 0), idx=0, go to FETCH.
  - PLAY held high after DONE does not restart; a new edge is required.
- FETCH: drive ROM_ADDR = {sel_q, idx}; go to LOAD next cycle.
- LOAD: capture ROM_DATA.
  - END=1, LOOP=1: idx=0, go to FETCH.
  - END=1, LOOP=0: pulse DONE for this one cycle, go to IDLE.
  - END=0: hp=HP; note length L = max(DUR,1) * (UNIT_CYCLES >> TEMPO); go to TONE with cnt=0, div=0.
- Note length L is exact: TONE lasts L-GAP_CYCLES cycles and GAP lasts GAP_CYCLES cycles.
- TONE, square wave:
  - hp=0 is a rest: SONG=0 throughout.
  - Otherwise div counts 0..hp; when div==hp, SONG toggles and div wraps to 0. Period is 2*(hp+1) cycles.
  - SONG starts at 0 for each note.
- GAP: SONG=0. At end of GAP, idx increments and the block goes to FETCH.
- Index wrap: idx reaching 2^IDX_W-1 without END is treated as END on the next load, i.e. wrap to 0 if LOOP=1, else finish.
- Fetch overhead: 2 cycles per note (FETCH+LOAD), not counted in L.
- PLAY low in any state: go to IDLE next cycle; SONG=0, BUSY=0, no DONE pulse.
- A PLAY rising edge coinciding with the DONE cycle is ignored.
- SEL/TEMPO changes mid-song: SEL is ignored until the next start; TEMPO takes effect at the next note load.
- Reset mid-note: immediate silence; state as at reset.
- Widths: duration counter sized for DUR_W max * UNIT_CYCLES; no overflow allowed.

Test Plan (UNIT_CYCLES=20, GAP_CYCLES=4, NUM_SONGS=2, IDX_W=3):
- Song0 = {HP=2, DUR=2}, {END}; PLAY rise, LOOP=0 -> FETCH at edge+1. SONG toggles every 3 cycles for 36 cycles, then 4 cycles at 0. DONE pulses once. BUSY falls the same cycle; NOTE_IDX=1 at the end.
- Rest note {HP=0, DUR=1} -> SONG stays 0 for 20 cycles while BUSY=1.
- Same song with LOOP=1 -> after END, ROM_ADDR returns to 0 and the note replays; DONE never pulses over 3 iterations.
- PLAY dropped mid-TONE at cycle 10 -> SONG=0 and BUSY=0 on the next cycle, no DONE. A new PLAY edge restarts from idx 0.
- SEL=1, TEMPO=1 -> ROM_ADDR=8..; a DUR=2 note lasts 20 cycles (16 tone + 4 gap). SEL changed to 0 mid-song has no effect.
- RESETN asserted mid-GAP -> all outputs return to reset values immediately. PLAY held high across reset release does not start; only a new edge does.
